tdm_demux8: RTL and testbench
=============================

TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 Parameter: DATA_W, default 1, width of one slot sample in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: din  input  DATA_W  serial TDM stream, one slot per enabled cycle.
REQ-005 Port: sync  input  1  frame-start strobe; marks the current din as slot 0.
REQ-006 Port: en  input  1  slot strobe; din is sampled only when en=1.
REQ-007 Port: d_out  output  8*DATA_W  registered frame; slot k at bits [k*DATA_W +: DATA_W].
REQ-008 Port: frame_valid  output  1  one-cycle pulse when d_out is updated.
REQ-009 Port: busy  output  1  high while a frame is partially captured.
REQ-010 Port: sync_err  output  1  one-cycle pulse when sync arrives mid-frame.
REQ-011 Port: parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.

Function
REQ-012 The FSM SHALL have states IDLE, RECV and, with parity compiled in, PAR.
REQ-013 IDLE: en=1 and sync=1 SHALL write din into shadow slot 0, set slot counter to 1 and go to RECV; en=1 with sync=0 SHALL be ignored.
REQ-014 RECV: each en=1 cycle SHALL write din into shadow[slot] and increment the 3-bit slot counter.
REQ-015 en=0 SHALL hold all state; frame_valid, sync_err and parity_err SHALL be 0 in that cycle.
REQ-016 Without parity, the edge that captures slot 7 SHALL load the 8 slots into d_out, pulse frame_valid for the following cycle, and return to IDLE.
REQ-017 Frame latency: d_out and frame_valid change on the same edge that samples slot 7 (or parity), with zero extra cycles.
REQ-018 sync=1 with en=1 while in RECV or PAR SHALL pulse sync_err, discard the partial frame, leave d_out unchanged, and restart with din as slot 0 (slot counter=1, state RECV).
REQ-019 sync=1 with en=1 on the slot-7 cycle SHALL be treated as REQ-018; the frame is not delivered.
REQ-020 Back-to-back frames SHALL be supported: sync may assert on the first enabled cycle after frame_valid.
REQ-021 busy SHALL be 1 in RECV and PAR and 0 in IDLE.
REQ-022 d_out SHALL hold its last value until the next valid frame.

Reset
REQ-023 When rst=1, the block SHALL immediately force: state IDLE, slot counter 0, shadow 0, d_out 0, frame_valid 0, busy 0, sync_err 0, parity_err 0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after release, the next capture SHALL begin only on sync.

Configuration
REQ-025 Macro TDM_DEMUX8_PARITY_EN: when defined, after slot 7 the FSM SHALL enter PAR and consume one more enabled din, using din[0] as the even-parity bit over all 8*DATA_W data bits.
REQ-026 With TDM_DEMUX8_PARITY_EN, a parity match SHALL load d_out and pulse frame_valid; a mismatch SHALL pulse parity_err, leave d_out unchanged, and return to IDLE.
REQ-027 Without TDM_DEMUX8_PARITY_EN, the PAR state and parity logic SHALL be absent and parity_err SHALL be constant 0.

Structure
REQ-028 A shared package tdm_pkg SHALL hold the FSM state typedef (IDLE, RECV, PAR), NUM_SLOTS=8, and the slot counter width 3.
REQ-029 A sub-module tdm_slot_ctr SHALL implement the slot counter with load-to-1, increment-on-en and clear.

Verification
REQ-030 With DATA_W=1, sync on slot 0 and en continuously high, din sequence 1,0,1,1,0,0,1,0 -> d_out=8'b0100_1101 and a single frame_valid pulse after the 8th edge.
REQ-031 With en toggling 1,0 on every cycle and the same frame as REQ-030 -> identical d_out, and frame_valid appears after the 15th enabled-or-idle cycle.
REQ-032 sync reasserted at slot 4 with a new frame of 0xFF -> sync_err pulse, previous d_out held, then d_out=8'hFF.
REQ-033 rst asserted at slot 3, then released, then a full 0xA5 frame sent -> d_out=0 during reset, then d_out=8'hA5 with exactly one frame_valid.
REQ-034 With TDM_DEMUX8_PARITY_EN, frame 0x07 with parity bit 1 -> frame_valid and d_out=8'h07; the same frame with parity bit 0 -> parity_err and d_out unchanged.
REQ-035 With DATA_W=4, two back-to-back frames with slots k=0..7 and value k, then 15-k -> d_out=32'h7654_3210, then 32'h89AB_CDEF, with no idle cycle between frames.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 8-slot TDM demultiplexer.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned SLOT_W    = 3;

  // PAR is only reached when TDM_DEMUX8_PARITY_EN is defined.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } tdm_state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for tdm_demux8: clear has priority over load-to-1, which
// has priority over increment. The counter wraps naturally at 8 slots.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              inc_i,
  output logic [SLOT_W-1:0] cnt_o
);

  logic [SLOT_W-1:0] cnt_q;
  logic [SLOT_W-1:0] cnt_d;

  // Next count selection.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = SLOT_W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + SLOT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux8.sv
// 8-slot TDM demultiplexer: captures one DATA_W sample per enabled cycle
// into a shadow frame starting at a sync strobe, then publishes the frame.
// Optional trailing even-parity beat: define TDM_DEMUX8_PARITY_EN.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int unsigned DATA_W = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           din,
  input  logic                        sync,
  input  logic                        en,
  output logic [NUM_SLOTS*DATA_W-1:0] d_out,
  output logic                        frame_valid,
  output logic                        busy,
  output logic                        sync_err,
  output logic                        parity_err
);

  localparam int unsigned FRAME_W = NUM_SLOTS * DATA_W;

  tdm_state_e         state_q, state_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [FRAME_W-1:0] d_out_q, d_out_d;
  logic               fv_q, fv_d;
  logic               se_q, se_d;
  logic               busy_q;
  logic               ctr_clr, ctr_load, ctr_inc;
  logic [SLOT_W-1:0]  slot_cnt;
`ifdef TDM_DEMUX8_PARITY_EN
  logic               pe_q, pe_d;
`endif

  tdm_slot_ctr u_slot_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (ctr_clr),
    .load_i (ctr_load),
    .inc_i  (ctr_inc),
    .cnt_o  (slot_cnt)
  );

  // Next-state, shadow capture and pulse generation; en=0 holds everything.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    d_out_d  = d_out_q;
    fv_d     = 1'b0;
    se_d     = 1'b0;
    ctr_clr  = 1'b0;
    ctr_load = 1'b0;
    ctr_inc  = 1'b0;
`ifdef TDM_DEMUX8_PARITY_EN
    pe_d     = 1'b0;
`endif
    if (en) begin
      case (state_q)
        IDLE: begin
          if (sync) begin
            shadow_d = FRAME_W'(din);
            ctr_load = 1'b1;
            state_d  = RECV;
          end
        end
        RECV: begin
          if (sync) begin
            // Mid-frame sync: drop the partial frame and restart at slot 0.
            se_d     = 1'b1;
            shadow_d = FRAME_W'(din);
            ctr_load = 1'b1;
          end else begin
            shadow_d[slot_cnt*DATA_W +: DATA_W] = din;
            ctr_inc = 1'b1;
            if (slot_cnt == SLOT_W'(NUM_SLOTS - 1)) begin
`ifdef TDM_DEMUX8_PARITY_EN
              state_d = PAR;
`else
              d_out_d = shadow_d;
              fv_d    = 1'b1;
              ctr_clr = 1'b1;
              state_d = IDLE;
`endif
            end
          end
        end
`ifdef TDM_DEMUX8_PARITY_EN
        PAR: begin
          if (sync) begin
            se_d     = 1'b1;
            shadow_d = FRAME_W'(din);
            ctr_load = 1'b1;
            state_d  = RECV;
          end else begin
            // din[0] completes even parity over the whole captured frame.
            if (din[0] == ^shadow_q) begin
              d_out_d = shadow_q;
              fv_d    = 1'b1;
            end else begin
              pe_d = 1'b1;
            end
            ctr_clr = 1'b1;
            state_d = IDLE;
          end
        end
`endif
        default: begin
          ctr_clr = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, frame and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      d_out_q  <= '0;
      fv_q     <= 1'b0;
      se_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      d_out_q  <= d_out_d;
      fv_q     <= fv_d;
      se_q     <= se_d;
      busy_q   <= (state_d != IDLE);
    end
  end

`ifdef TDM_DEMUX8_PARITY_EN
  // Parity error pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_q <= 1'b0;
    end else begin
      pe_q <= pe_d;
    end
  end

  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

  assign d_out       = d_out_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8 (DATA_W=1 and DATA_W=4 instances),
// with a queue-free frame-level reference model for the DATA_W=1 instance.
module tb_tdm_demux8;

`ifdef TDM_DEMUX8_PARITY_EN
  localparam int NBEAT = 9;
`else
  localparam int NBEAT = 8;
`endif

  logic        clk;
  logic        rst;
  logic        din;
  logic        sync;
  logic        en;
  logic [7:0]  d_out;
  logic        frame_valid, busy, sync_err, parity_err;

  logic [3:0]  din4;
  logic        sync4, en4;
  logic [31:0] d_out4;
  logic        fv4, busy4, se4, pe4;

  int errors = 0;
  int checks = 0;

  // Reference model state for the DATA_W=1 instance.
  bit         m_in_frame;
  bit         m_wait_par;
  logic [7:0] m_frame;
  int         m_n;
  logic [7:0] m_dout;
  bit         m_fv, m_se, m_pe;

  tdm_demux8 #(.DATA_W(1)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .sync        (sync),
    .en          (en),
    .d_out       (d_out),
    .frame_valid (frame_valid),
    .busy        (busy),
    .sync_err    (sync_err),
    .parity_err  (parity_err)
  );

  tdm_demux8 #(.DATA_W(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .din         (din4),
    .sync        (sync4),
    .en          (en4),
    .d_out       (d_out4),
    .frame_valid (fv4),
    .busy        (busy4),
    .sync_err    (se4),
    .parity_err  (pe4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] obs1();
    return {d_out, frame_valid, busy, sync_err, parity_err};
  endfunction

  function automatic logic [11:0] exp1();
    return {m_dout, m_fv, m_in_frame, m_se, m_pe};
  endfunction

  function automatic bit beat_bit(input logic [7:0] v, input int k);
    if (k < 8) return v[k];
    return ^v;
  endfunction

  function automatic logic [3:0] beat4(input logic [31:0] v, input int k);
    if (k < 8) return v[k*4 +: 4];
    return {3'b000, ^v};
  endfunction

  task automatic model_reset();
    m_in_frame = 0; m_wait_par = 0; m_frame = '0; m_n = 0;
    m_dout = '0; m_fv = 0; m_se = 0; m_pe = 0;
  endtask

  // Frame-level behaviour: what an enabled cycle does to the frame in flight.
  task automatic model_update(input bit e, input bit s, input bit d);
    m_fv = 0; m_se = 0; m_pe = 0;
    if (e) begin
      if (s) begin
        if (m_in_frame) m_se = 1;
        m_in_frame = 1; m_wait_par = 0; m_frame = '0; m_frame[0] = d; m_n = 1;
      end else if (m_in_frame) begin
        if (m_wait_par) begin
          if (d == ^m_frame) begin m_dout = m_frame; m_fv = 1; end
          else m_pe = 1;
          m_in_frame = 0; m_wait_par = 0;
        end else begin
          m_frame[m_n] = d;
          m_n++;
          if (m_n == 8) begin
`ifdef TDM_DEMUX8_PARITY_EN
            m_wait_par = 1;
`else
            m_dout = m_frame; m_fv = 1; m_in_frame = 0;
`endif
          end
        end
      end
    end
  endtask

  // Drive one cycle on the DATA_W=1 instance and advance the model.
  task automatic step1(input bit e, input bit s, input bit d);
    en = e; sync = s; din = d;
    @(posedge clk);
    model_update(e, s, d);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 0; sync = 0; din = 0; en4 = 0; sync4 = 0; din4 = '0;
    model_reset();
    #2;
    checks++;
    if (obs1() !== 12'h000) begin
      errors++; $display("FAIL reset_w1: got %h want %h", obs1(), 12'h000);
    end
    checks++;
    if ({d_out4, fv4, busy4, se4, pe4} !== 36'h0) begin
      errors++; $display("FAIL reset_w4: got %h want 0", {d_out4, fv4, busy4, se4, pe4});
    end
    @(negedge clk);
    rst = 1'b0;
    // en without sync in IDLE is ignored.
    for (int i = 0; i < 3; i++) begin
      step1(1, 0, 1);
      checks++;
      if (obs1() !== exp1()) begin
        errors++; $display("FAIL idle_nosync cyc%0d: got %h want %h", i, obs1(), exp1());
      end
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] v = 8'b0100_1101;
    int fv_cnt = 0;
    for (int k = 0; k < NBEAT; k++) begin
      step1(1, k == 0, beat_bit(v, k));
      if (frame_valid) fv_cnt++;
      checks++;
      if (obs1() !== exp1()) begin
        errors++; $display("FAIL basic cyc%0d: got %h want %h", k, obs1(), exp1());
      end
    end
    step1(0, 0, 0);
    checks++;
    if (d_out !== 8'h4D || fv_cnt != 1 || frame_valid !== 1'b0) begin
      errors++; $display("FAIL basic_result: got d_out=%h pulses=%0d want d_out=4d pulses=1", d_out, fv_cnt);
    end
  endtask

  task automatic test_en_gaps();
    logic [7:0] v = 8'b0100_1101;
    int fv_cyc = -1;
    step1(0, 0, 0);
    for (int i = 0; i < 2*NBEAT; i++) begin
      bit e = (i % 2 == 0);
      int k = i / 2;
      step1(e, e && k == 0, beat_bit(v, k));
      if (frame_valid) fv_cyc = i + 1;
      checks++;
      if (obs1() !== exp1()) begin
        errors++; $display("FAIL en_gaps cyc%0d: got %h want %h", i, obs1(), exp1());
      end
    end
    checks++;
    if (fv_cyc != 2*NBEAT - 1 || d_out !== 8'h4D) begin
      errors++; $display("FAIL en_gaps_result: got cycle=%0d d_out=%h want cycle=%0d d_out=4d",
                         fv_cyc, d_out, 2*NBEAT - 1);
    end
  endtask

  task automatic test_sync_restart();
    logic [7:0] v = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      step1(1, k == 0, v[k]);
      checks++;
      if (obs1() !== exp1()) begin
        errors++; $display("FAIL restart_pre cyc%0d: got %h want %h", k, obs1(), exp1());
      end
    end
    for (int k = 0; k < NBEAT; k++) begin
      step1(1, k == 0, beat_bit(8'hFF, k));
      checks++;
      if (obs1() !== exp1()) begin
        errors++; $display("FAIL restart cyc%0d: got %h want %h", k, obs1(), exp1());
      end
      if (k == 0) begin
        checks++;
        if (sync_err !== 1'b1 || d_out !== 8'h4D) begin
          errors++; $display("FAIL restart_err: got sync_err=%b d_out=%h want 1 4d", sync_err, d_out);
        end
      end
    end
    checks++;
    if (d_out !== 8'hFF) begin
      errors++; $display("FAIL restart_result: got %h want ff", d_out);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] v = 8'h5A;
    int fv_cnt = 0;
    for (int k = 0; k < 3; k++) step1(1, k == 0, v[k]);
    en = 1; sync = 0; din = v[3];
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs1() !== 12'h000) begin
      errors++; $display("FAIL reset_mid: got %h want %h", obs1(), 12'h000);
    end
    en = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (d_out !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got d_out=%h busy=%b want 00 0", d_out, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step1(1, 0, v[i]);
      checks++;
      if (obs1() !== exp1()) begin
        errors++; $display("FAIL post_reset_idle cyc%0d: got %h want %h", i, obs1(), exp1());
      end
    end
    for (int k = 0; k < NBEAT; k++) begin
      step1(1, k == 0, beat_bit(8'hA5, k));
      if (frame_valid) fv_cnt++;
      checks++;
      if (obs1() !== exp1()) begin
        errors++; $display("FAIL post_reset cyc%0d: got %h want %h", k, obs1(), exp1());
      end
    end
    step1(0, 0, 0);
    checks++;
    if (d_out !== 8'hA5 || fv_cnt != 1) begin
      errors++; $display("FAIL post_reset_result: got d_out=%h pulses=%0d want a5 1", d_out, fv_cnt);
    end
  endtask

`ifdef TDM_DEMUX8_PARITY_EN
  task automatic test_parity();
    logic [7:0] v = 8'h07;
    for (int k = 0; k < 9; k++) begin
      step1(1, k == 0, (k < 8) ? v[k] : 1'b1);
      checks++;
      if (obs1() !== exp1()) begin
        errors++; $display("FAIL parity_ok cyc%0d: got %h want %h", k, obs1(), exp1());
      end
    end
    checks++;
    if (frame_valid !== 1'b1 || d_out !== 8'h07) begin
      errors++; $display("FAIL parity_ok_result: got fv=%b d_out=%h want 1 07", frame_valid, d_out);
    end
    step1(1, 0, 0);
    step1(1, 0, 0);
    for (int k = 0; k < 9; k++) begin
      step1(1, k == 0, (k < 8) ? v[k] : 1'b0);
      checks++;
      if (obs1() !== exp1()) begin
        errors++; $display("FAIL parity_bad cyc%0d: got %h want %h", k, obs1(), exp1());
      end
    end
    checks++;
    if (parity_err !== 1'b1 || frame_valid !== 1'b0 || d_out !== 8'h07) begin
      errors++; $display("FAIL parity_bad_result: got pe=%b fv=%b d_out=%h want 1 0 07",
                         parity_err, frame_valid, d_out);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] prev = 32'h0;
    for (int f = 0; f < 2; f++) begin
      logic [31:0] val = (f == 0) ? 32'h7654_3210 : 32'h89AB_CDEF;
      for (int k = 0; k < NBEAT; k++) begin
        bit last = (k == NBEAT - 1);
        logic [35:0] want = {last ? val : prev, last, !last, 1'b0, 1'b0};
        en4 = 1; sync4 = (k == 0); din4 = beat4(val, k);
        @(posedge clk);
        #1;
        checks++;
        if ({d_out4, fv4, busy4, se4, pe4} !== want) begin
          errors++; $display("FAIL b2b f%0d cyc%0d: got %h want %h", f, k,
                             {d_out4, fv4, busy4, se4, pe4}, want);
        end
      end
      prev = val;
    end
    en4 = 0; sync4 = 0;
    @(posedge clk);
    #1;
    checks++;
    if (d_out4 !== 32'h89AB_CDEF || fv4 !== 1'b0) begin
      errors++; $display("FAIL b2b_hold: got d_out=%h fv=%b want 89abcdef 0", d_out4, fv4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit e = ($urandom_range(0, 9) < 7);
      bit s = ($urandom_range(0, 15) == 0);
      bit d = 1'($urandom_range(0, 1));
      step1(e, s, d);
      checks++;
      if (obs1() !== exp1()) begin
        errors++; $display("FAIL random cyc%0d: got %h want %h", i, obs1(), exp1());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_en_gaps();
    test_sync_restart();
    test_reset_midframe();
`ifdef TDM_DEMUX8_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
